// File: rtl/scan_chain_host.sv
// Host end of the processor scan chain: shifts a byte-streamed image in
// while returning the previous chain contents, then can run until halt.
module scan_chain_host #(
    parameter int CHAIN_LEN  = 152,
    parameter int BYTE_CNT_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_load,
    input  logic       cmd_run,
    output logic       busy,
    output logic       halted,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       chain_scan_enable,
    output logic       chain_scan_in,
    input  logic       chain_scan_out,
    output logic       chain_proc_en,
    input  logic       chain_halt
);

    localparam int NB        = (CHAIN_LEN + 7) / 8;
    localparam int LAST_BITS = CHAIN_LEN - 8 * (NB - 1);
    localparam logic [BYTE_CNT_W-1:0] NB_C  = BYTE_CNT_W'(NB);
    localparam logic [BYTE_CNT_W-1:0] NB_M1 = BYTE_CNT_W'(NB - 1);

    typedef enum logic [2:0] {IDLE, GET, SHIFT, PUT, RUN} state_t;

    state_t                state_q, state_d;
    logic [7:0]            shift_q, shift_d;
    logic [7:0]            cap_q, cap_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic                  halted_q, halted_d;
    logic                  busy_q, busy_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [7:0]            out_data_q, out_data_d;
    logic                  scan_en_q, scan_en_d;
    logic                  scan_in_q, scan_in_d;
    logic                  proc_en_q, proc_en_d;
    logic [3:0]            nbits;

    assign nbits = (byte_cnt_q == NB_M1) ? 4'(LAST_BITS) : 4'd8;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cap_d      = cap_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        halted_d   = halted_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_load) begin
                    state_d    = GET;
                    halted_d   = 1'b0;
                    byte_cnt_d = '0;
                end else if (cmd_run) begin
                    state_d = RUN;
                end
            end
            GET: begin
                if (in_valid) begin
                    shift_d   = in_data;
                    cap_d     = 8'h00;
                    bit_cnt_d = 4'd0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                cap_d[bit_cnt_q[2:0]] = chain_scan_out;
                shift_d   = {1'b0, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == nbits - 4'd1) begin
                    state_d    = PUT;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
            end
            PUT: begin
                if (out_ready) begin
                    state_d = (byte_cnt_q == NB_C) ? IDLE : GET;
                end
            end
            RUN: begin
                // A load aborts the run without flagging a halt
                if (cmd_load) begin
                    state_d    = GET;
                    halted_d   = 1'b0;
                    byte_cnt_d = '0;
                end else if (chain_halt) begin
                    state_d  = IDLE;
                    halted_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d      = (state_d != IDLE);
        in_ready_d  = (state_d == GET);
        out_valid_d = (state_d == PUT);
        out_data_d  = (state_d == PUT) ? cap_d : 8'h00;
        scan_en_d   = (state_d == SHIFT);
        scan_in_d   = (state_d == SHIFT) & shift_d[0];
        proc_en_d   = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= 8'h00;
            cap_q       <= 8'h00;
            bit_cnt_q   <= 4'd0;
            byte_cnt_q  <= '0;
            halted_q    <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            scan_en_q   <= 1'b0;
            scan_in_q   <= 1'b0;
            proc_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cap_q       <= cap_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            halted_q    <= halted_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            scan_en_q   <= scan_en_d;
            scan_in_q   <= scan_in_d;
            proc_en_q   <= proc_en_d;
        end
    end

    assign busy              = busy_q;
    assign halted            = halted_q;
    assign in_ready          = in_ready_q;
    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign chain_scan_enable = scan_en_q;
    assign chain_scan_in     = scan_in_q;
    assign chain_proc_en     = proc_en_q;

endmodule

// File: tb/tb_scan_chain_host.sv
// Bench for scan_chain_host on a 12-flop chain model with a
// scoreboard of expected returned bytes.
module tb_scan_chain_host;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_load = 1'b0;
    logic       cmd_run = 1'b0;
    logic       busy, halted;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       chain_scan_enable, chain_scan_in;
    logic       chain_scan_out;
    logic       chain_proc_en;
    logic       chain_halt = 1'b0;

    logic [11:0] chain;
    logic        preload = 1'b1;
    int          se_cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];

    scan_chain_host #(.CHAIN_LEN(12), .BYTE_CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .cmd_load(cmd_load), .cmd_run(cmd_run),
        .busy(busy), .halted(halted),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .chain_scan_enable(chain_scan_enable),
        .chain_scan_in(chain_scan_in),
        .chain_scan_out(chain_scan_out),
        .chain_proc_en(chain_proc_en),
        .chain_halt(chain_halt)
    );

    always #5 clk = ~clk;

    // Processor scan chain: shifts toward bit 0 while enabled
    assign chain_scan_out = chain[0];
    always @(posedge clk) begin
        if (preload) chain <= 12'h93C;
        else if (chain_scan_enable) chain <= {chain_scan_in, chain[11:1]};
        if (chain_scan_enable) se_cnt <= se_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
            else chk("out_byte", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_scan_en"}, chain_scan_enable, 0);
        chk({tag, "_scan_in"}, chain_scan_in, 0);
        chk({tag, "_proc_en"}, chain_proc_en, 0);
    endtask

    task automatic pulse_load();
        cmd_load = 1'b1;
        step();
        cmd_load = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic [7:0] e);
        int n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
        exp_q.push_back(e);
        in_data  = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        chk("idle_wait", busy, 0);
    endtask

    task automatic xfer(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] e0, input logic [7:0] e1);
        int s0 = se_cnt;
        pulse_load();
        send(b0, e0);
        send(b1, e1);
        wait_idle();
        chk("se_cycles", se_cnt - s0, 12);
    endtask

    initial begin
        int s0;
        int n;
        logic [11:0] snap;
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int n;
        logic [11:0] snap;
        repeat (3) step();
        rst = 1'b0;
        preload = 1'b0;
        step();
        check_zero("reset");

        // 1/2: returned bytes are the previous image, LSB first
        xfer(8'hA5, 8'h03, 8'h3C, 8'h09);
        xfer(8'h00, 8'h00, 8'hA5, 8'h03);
        xfer(8'h3C, 8'h09, 8'h00, 8'h00);

        // 3: output stall holds the byte and the chain
        out_ready = 1'b0;
        s0 = se_cnt;
        pulse_load();
        send(8'h5A, 8'h3C);
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        chk("stall_valid_wait", out_valid, 1);
        snap = chain;
        n = se_cnt;
        repeat (5) begin
            chk("stall_data", out_data, 8'h3C);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_valid", out_valid, 1);
            step();
        end
        chk("stall_no_shift", se_cnt - n, 0);
        chk("stall_chain", chain, snap);
        out_ready = 1'b1;
        send(8'h06, 8'h09);
        wait_idle();
        chk("stall_se_cycles", se_cnt - s0, 12);

        // 4: run until halt
        cmd_run = 1'b1;
        step();
        cmd_run = 1'b0;
        n = 0;
        repeat (7) begin
            if (chain_proc_en) n++;
            chk("run_busy", busy, 1);
            step();
        end
        chk("run_cycles", n, 7);
        chain_halt = 1'b1;
        step();
        chain_halt = 1'b0;
        chk("halt_proc_en", chain_proc_en, 0);
        chk("halt_flag", halted, 1);
        chk("halt_busy", busy, 0);
        repeat (4) step();
        chk("halt_sticky", halted, 1);

        // 5: load aborts a run
        cmd_run = 1'b1;
        step();
        cmd_run = 1'b0;
        step();
        chk("run2_proc_en", chain_proc_en, 1);
        chk("run2_halted_kept", halted, 1);
        pulse_load();
        chk("abort_proc_en", chain_proc_en, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_halted", halted, 0);
        send(8'h81, 8'h5A);
        send(8'h0F, 8'h06);
        wait_idle();
        chk("abort_halted_end", halted, 0);

        // 6: reset in the middle of a shift
        s0 = se_cnt;
        pulse_load();
        send(8'hFF, 8'h00);
        n = 0;
        while (se_cnt - s0 < 3 && n < 50) begin
            step();
            n++;
        end
        chk("mid_shift_bits", se_cnt - s0, 3);
        rst = 1'b1;
        step();
        exp_q.delete();
        check_zero("mid_reset");
        rst = 1'b0;
        step();
        snap = chain;
        xfer(8'h12, 8'h03, snap[7:0], {4'h0, snap[11:8]});
        xfer(8'h00, 8'h00, 8'h12, 8'h03);

        chk("sb_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
